// File: rtl/byte2bcd.sv
// rtl/byte2bcd.sv - registered 8-bit binary to 3-digit packed BCD converter
module byte2bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  byte_in,
    output logic        out_valid,
    output logic [11:0] bcd_out
);

    logic [19:0] dabble;
    logic [11:0] bcd_next;

    // Shift-add-3: BCD digits live in dabble[19:8], the binary operand in [7:0].
    always_comb begin
        dabble = {12'h000, byte_in};
        for (int i = 0; i < 8; i++) begin
            if (dabble[11:8] >= 4'd5)
                dabble[11:8] = dabble[11:8] + 4'd3;
            if (dabble[15:12] >= 4'd5)
                dabble[15:12] = dabble[15:12] + 4'd3;
            if (dabble[19:16] >= 4'd5)
                dabble[19:16] = dabble[19:16] + 4'd3;
            dabble = dabble << 1;
        end
        bcd_next = dabble[19:8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            bcd_out   <= 12'h000;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                bcd_out <= bcd_next;
        end
    end

endmodule

// File: tb/tb_byte2bcd.sv
// tb/tb_byte2bcd.sv - scoreboard bench for byte2bcd
module tb_byte2bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b1;
    logic [7:0]  byte_in = 8'hFF;
    logic        out_valid;
    logic [11:0] bcd_out;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    byte2bcd dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .byte_in   (byte_in),
        .out_valid (out_valid),
        .bcd_out   (bcd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] dec_of(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %03h, expected %03h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic [11:0] exp_val);
        @(posedge clk);
        #1;
        in_valid = v;
        byte_in  = b;
        if (v) exp_q.push_back(exp_val);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 12'(exp_q.size()), 12'd0);
    endtask

    // Monitor: every out_valid pulse consumes one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got bcd %03h, expected no output", bcd_out);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("bcd_value", bcd_out, e);
                checks++;
                if (bcd_out[11:8] > 4'd2 || bcd_out[7:4] > 4'd9 || bcd_out[3:0] > 4'd9) begin
                    errors++;
                    $display("FAIL nibble_range: got %03h, expected digits within 2/9/9", bcd_out);
                end
            end
        end
    end

    logic [7:0]  roll_in  [7] = '{8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd200, 8'd255};
    logic [11:0] roll_exp [7] = '{12'h009, 12'h010, 12'h099, 12'h100, 12'h199, 12'h200, 12'h255};

    initial begin
        // Reset held with valid input present
        repeat (3) begin
            @(negedge clk);
            check("reset_bcd", bcd_out, 12'h000);
            check("reset_valid", {11'd0, out_valid}, 12'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;

        // Exhaustive back-to-back stream
        for (int i = 0; i < 256; i++)
            drive(1'b1, 8'(i), dec_of(i));
        drive(1'b0, 8'd0, 12'h000);
        drain();

        // Digit rollovers, hand-computed
        for (int i = 0; i < 7; i++)
            drive(1'b1, roll_in[i], roll_exp[i]);
        drive(1'b0, 8'd0, 12'h000);
        drain();

        // Hold with in_valid low
        drive(1'b1, 8'd42, 12'h042);
        drive(1'b0, 8'd77, 12'h000);
        @(negedge clk);
        repeat (4) begin
            @(negedge clk);
            check("hold_bcd", bcd_out, 12'h042);
            check("hold_valid", {11'd0, out_valid}, 12'd0);
        end

        // Asynchronous reset between edges while streaming
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        byte_in  = 8'd123;
        @(posedge clk);
        #2;
        check("stream_before_rst_bcd", bcd_out, 12'h123);
        check("stream_before_rst_valid", {11'd0, out_valid}, 12'd1);
        rst = 1'b1;
        #1;
        check("async_rst_bcd", bcd_out, 12'h000);
        check("async_rst_valid", {11'd0, out_valid}, 12'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 8'd250, 12'h250);
        drive(1'b0, 8'd0, 12'h000);
        drain();

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
